dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU port 0 has priority, loader/debug port 1 is
// force-granted after STARVE_LIMIT consecutive denied cycles. One-deep read response pipe.
module dmem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic [3:0]        p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,

    input  logic              p1_req,
    input  logic [3:0]        p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic [7:0]        starve_cnt
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;
    logic       r_rsp_valid;
    logic       r_rsp_tag;     // 0 = response belongs to port 0, 1 = port 1

    logic       w_force;
    logic       w_p0_gnt;
    logic       w_p1_gnt;
    logic       w_rd_accept;
    logic       w_p0_rvalid;
    logic       w_p1_rvalid;

    // Grants are gated by rst so nothing can be accepted while reset is held.
    assign w_force  = (r_starve_cnt == LIMIT);
    assign w_p1_gnt = !rst && p1_req && (w_force || !p0_req);
    assign w_p0_gnt = !rst && p0_req && !w_p1_gnt;

    assign w_rd_accept = (w_p0_gnt && (p0_we == 4'b0000)) ||
                         (w_p1_gnt && (p1_we == 4'b0000));

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (w_p0_gnt) begin
            mem_en    = 1'b1;
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (w_p1_gnt) begin
            mem_en    = 1'b1;
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 8'h00;
            r_rsp_valid  <= 1'b0;
            r_rsp_tag    <= 1'b0;
        end else begin
            if (!p1_req || w_p1_gnt) begin
                r_starve_cnt <= 8'h00;
            end else if (r_starve_cnt != LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 8'h01;
            end
            r_rsp_valid <= w_rd_accept;
            r_rsp_tag   <= w_p1_gnt;
        end
    end

    // A read accepted just before reset rises must not surface during reset.
    assign w_p0_rvalid = !rst && r_rsp_valid && !r_rsp_tag;
    assign w_p1_rvalid = !rst && r_rsp_valid &&  r_rsp_tag;

    assign p0_gnt     = w_p0_gnt;
    assign p1_gnt     = w_p1_gnt;
    assign p0_rvalid  = w_p0_rvalid;
    assign p1_rvalid  = w_p1_rvalid;
    assign p0_rdata   = w_p0_rvalid ? mem_rdata : 32'h0;
    assign p1_rdata   = w_p1_rvalid ? mem_rdata : 32'h0;
    assign starve_cnt = rst ? 8'h00 : r_starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory environment, per-cycle reference model compare,
// and directed scenarios with literal expectations.
module tb_dmem_arbiter;
    localparam int ADDR_W = 14;
    localparam int LIMIT  = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p1_req;
    logic [3:0]        p0_we, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [31:0]       p0_wdata, p1_wdata;
    logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic [7:0]        starve_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] env_mem [DEPTH];
    logic [31:0] mdl_mem [DEPTH];

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Memory environment: one-cycle read latency, byte-lane writes, junk when not reading.
    always @(posedge clk) begin
        if (mem_en && mem_we == 4'b0000) begin
            mem_rdata <= env_mem[mem_addr];
        end else begin
            mem_rdata <= $urandom;
        end
        if (mem_en && mem_we != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: grant decision from the priority/starvation rule, read data
    // taken from the model's own copy of memory.
    int          m_wait = 0;
    bit          m_pv = 0;
    bit          m_pp = 0;
    logic [31:0] m_pd = 32'h0;
    int          obs_wait = 0;
    int          max_wait = 0;

    always @(negedge clk) begin
        bit          e_p0, e_p1, e_en;
        logic [3:0]  e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0] e_wd;
        int          e_st;
        if (rst) begin
            e_p0 = 0; e_p1 = 0; e_st = 0;
        end else begin
            e_p1 = p1_req && (!p0_req || m_wait >= LIMIT);
            e_p0 = p0_req && !e_p1;
            e_st = (m_wait > LIMIT) ? LIMIT : m_wait;
        end
        e_en   = e_p0 || e_p1;
        e_we   = e_p0 ? p0_we    : (e_p1 ? p1_we    : 4'b0);
        e_addr = e_p0 ? p0_addr  : (e_p1 ? p1_addr  : '0);
        e_wd   = e_p0 ? p0_wdata : (e_p1 ? p1_wdata : 32'h0);

        chk("gnt",        32'({p0_gnt, p1_gnt}), 32'({e_p0, e_p1}));
        chk("mem_bus",    32'({mem_en, mem_we, mem_addr}), 32'({e_en, e_we, e_addr}));
        chk("mem_wdata",  mem_wdata, e_wd);
        chk("starve_cnt", 32'(starve_cnt), 32'(e_st));
        if (rst) begin
            chk("rvalid_rst", 32'({p0_rvalid, p1_rvalid}), 32'h0);
        end else begin
            chk("rvalid",   32'({p0_rvalid, p1_rvalid}), 32'({m_pv && !m_pp, m_pv && m_pp}));
            chk("p0_rdata", p0_rdata, (m_pv && !m_pp) ? m_pd : 32'h0);
            chk("p1_rdata", p1_rdata, (m_pv &&  m_pp) ? m_pd : 32'h0);
        end

        if (rst) begin
            m_wait = 0; m_pv = 0;
        end else begin
            m_pv = e_en && (e_we == 4'b0000);
            m_pp = e_p1;
            if (m_pv) m_pd = mdl_mem[e_addr];
            if (e_en && e_we != 4'b0000)
                for (int b = 0; b < 4; b++)
                    if (e_we[b]) mdl_mem[e_addr][8*b +: 8] = e_wd[8*b +: 8];
            m_wait = (p1_req && !e_p1) ? m_wait + 1 : 0;
        end

        if (!rst && p1_req && !p1_gnt) obs_wait++;
        else obs_wait = 0;
        if (obs_wait > max_wait) max_wait = obs_wait;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit r0, input logic [3:0] w0, input logic [ADDR_W-1:0] a0,
                         input logic [31:0] d0, input bit r1, input logic [3:0] w1,
                         input logic [ADDR_W-1:0] a1, input logic [31:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 4'h0, '0, 32'h0, 0, 4'h0, '0, 32'h0);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            env_mem[a] = 32'hC0DE0000 | 32'(a);
            mdl_mem[a] = 32'hC0DE0000 | 32'(a);
        end
        env_mem[16] = 32'hDEADBEEF;
        mdl_mem[16] = 32'hDEADBEEF;

        rst = 1'b1;
        drive(1, 4'h0, 14'h001, 32'h0, 1, 4'h0, 14'h002, 32'h0);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_gnt",    32'({p0_gnt, p1_gnt}), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_starve", 32'(starve_cnt), 32'h0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        // p0 single read of a preset word
        drive(1, 4'h0, 14'h010, 32'h0, 0, 4'h0, '0, 32'h0);
        @(negedge clk);
        chk("lit_p0_gnt",  32'(p0_gnt), 32'h1);
        chk("lit_addr10",  32'(mem_addr), 32'h010);
        tick(); idle();
        @(negedge clk);
        chk("lit_p0_rv",   32'({p0_rvalid, p1_rvalid}), 32'h2);
        chk("lit_p0_rd",   p0_rdata, 32'hDEADBEEF);
        tick();

        // p1 partial write to top address, then read it back through p0
        drive(0, 4'h0, '0, 32'h0, 1, 4'b0011, 14'h3FFF, 32'h12345678);
        @(negedge clk);
        chk("lit_wr_bus",  32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 4'b0011, 14'h3FFF}));
        chk("lit_wr_data", mem_wdata, 32'h12345678);
        tick(); idle();
        @(negedge clk);
        chk("lit_wr_norv", 32'({p0_rvalid, p1_rvalid}), 32'h0);
        tick();
        drive(1, 4'h0, 14'h3FFF, 32'h0, 0, 4'h0, '0, 32'h0);
        tick(); idle();
        @(negedge clk);
        chk("lit_partial", p0_rdata, 32'hC0DE5678);
        tick();

        // back-to-back reads from alternating ports
        drive(1, 4'h0, 14'h020, 32'h0, 0, 4'h0, '0, 32'h0);
        tick();
        drive(0, 4'h0, '0, 32'h0, 1, 4'h0, 14'h021, 32'h0);
        @(negedge clk);
        chk("lit_b2b_p0",  p0_rdata, 32'hC0DE0020);
        chk("lit_b2b_g1",  32'(p1_gnt), 32'h1);
        tick(); idle();
        @(negedge clk);
        chk("lit_b2b_p1",  p1_rdata, 32'hC0DE0021);
        chk("lit_b2b_rv",  32'({p0_rvalid, p1_rvalid}), 32'h1);
        tick();

        // continuous contention: p1 wins every 9th cycle
        for (int i = 0; i < 18; i++) begin
            drive(1, 4'h0, 14'(i), 32'h0, 1, 4'h0, 14'(100 + i), 32'h0);
            @(negedge clk);
            chk("lit_starve_g", 32'({p0_gnt, p1_gnt}), (i % 9 == 8) ? 32'h1 : 32'h2);
            chk("lit_starve_c", 32'(starve_cnt), 32'(i % 9));
            tick();
        end
        idle();
        tick();

        // read granted right before reset
        drive(0, 4'h0, '0, 32'h0, 1, 4'h0, 14'h005, 32'h0);
        @(negedge clk);
        chk("lit_pre_rst", 32'(p1_gnt), 32'h1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("lit_rst_rv",  32'({p0_rvalid, p1_rvalid, p1_gnt, mem_en}), 32'h0);
        chk("lit_rst_st",  32'(starve_cnt), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_post_g",  32'(p1_gnt), 32'h1);
        chk("lit_post_rv", 32'(p1_rvalid), 32'h0);
        tick();

        // mixed traffic on both ports
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 4'(($urandom_range(1, 15))) : 4'h0,
                  14'($urandom_range(0, 63)), $urandom,
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 4'(($urandom_range(1, 15))) : 4'h0,
                  14'($urandom_range(0, 63)), $urandom);
            tick();
        end
        // heavy p0 load against a persistent p1
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 7) != 0, 4'h0, 14'($urandom_range(0, 63)), 32'h0,
                  1, ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0, 14'($urandom_range(0, 63)), $urandom);
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        chk("p1_max_wait", 32'(max_wait <= LIMIT), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
